// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO: gray-coded pointer CDC, programmable flags, occupancy counts, reset-busy handshake.
// Define ASYNC_FIFO_FWFT_EN for first-word-fall-through reads; standard read mode otherwise.
module async_fifo_gray #(
   parameter int unsigned DATA_W            = 37,
   parameter int unsigned DEPTH             = 256,
   parameter int unsigned SYNC_STAGES       = 2,
   parameter int unsigned PROG_FULL_THRESH  = DEPTH - 16,
   parameter int unsigned PROG_EMPTY_THRESH = 16
) (
   input  logic                   wr_clk,
   input  logic                   srst,
   input  logic                   rd_clk,
   input  logic [DATA_W-1:0]      din,
   input  logic                   wr_en,
   output logic                   full,
   output logic                   prog_full,
   output logic [$clog2(DEPTH):0] wr_count,
   output logic                   overflow,
   output logic                   wr_rst_busy,
   input  logic                   rd_en,
   output logic [DATA_W-1:0]      dout,
   output logic                   valid,
   output logic                   empty,
   output logic                   prog_empty,
   output logic [$clog2(DEPTH):0] rd_count,
   output logic                   underflow,
   output logic                   rd_rst_busy
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam logic [PTR_W-1:0] PF_TH = PTR_W'(PROG_FULL_THRESH);
   localparam logic [PTR_W-1:0] PE_TH = PTR_W'(PROG_EMPTY_THRESH);

   function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
      logic [PTR_W-1:0] b;
      b = g;
      for (int i = 1; i < int'(PTR_W); i++) b = b ^ (g >> i);
      return b;
   endfunction

   logic [DATA_W-1:0] mem_q [DEPTH];

   // write-domain state
   logic                              wr_rst_busy_q, wr_rst_busy_d;
   logic [SYNC_STAGES-1:0]            rd_ack_q, rd_ack_d;
   logic [PTR_W-1:0]                  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                  wr_gray_q, wr_gray_d;
   logic [SYNC_STAGES-1:0][PTR_W-1:0] rd_gray_sync_q, rd_gray_sync_d;
   logic                              full_q, full_d;
   logic                              prog_full_q, prog_full_d;
   logic                              overflow_q, overflow_d;
   logic [PTR_W-1:0]                  wr_count_q, wr_count_d;
   logic                              wr_push_c;
   logic [PTR_W-1:0]                  rd_ptr_sync_c, full_gray_c;

   // read-domain state
   logic [SYNC_STAGES-1:0]            rd_rst_sync_q, rd_rst_sync_d;
   logic [SYNC_STAGES-1:0][PTR_W-1:0] wr_gray_sync_q, wr_gray_sync_d;
   logic [PTR_W-1:0]                  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]                  rd_gray_q, rd_gray_d;
   logic                              ram_empty_q, ram_empty_d;
   logic                              empty_q, empty_d;
   logic                              prog_empty_q, prog_empty_d;
   logic                              valid_q, valid_d;
   logic                              underflow_q, underflow_d;
   logic [DATA_W-1:0]                 dout_q, dout_d;
   logic [PTR_W-1:0]                  rd_count_q, rd_count_d;
   logic                              rd_rst_now_c, rd_rst_next_c, ram_pop_c;
   logic [PTR_W-1:0]                  wr_ptr_sync_c;
   logic [DATA_W-1:0]                 rd_data_c;

   // Reset request is held until the read domain echoes it, so a short srst is never missed.
   always_comb begin
      rd_ack_d       = {rd_ack_q[SYNC_STAGES-2:0], rd_rst_sync_q[SYNC_STAGES-1]};
      wr_rst_busy_d  = srst | (wr_rst_busy_q & ~rd_ack_q[SYNC_STAGES-1]);
      wr_push_c      = wr_en & ~full_q & ~wr_rst_busy_q & ~srst;
      rd_gray_sync_d = wr_rst_busy_d ? '0 : {rd_gray_sync_q[SYNC_STAGES-2:0], rd_gray_q};
      rd_ptr_sync_c  = gray2bin(rd_gray_sync_q[SYNC_STAGES-1]);
      full_gray_c    = {~rd_gray_sync_q[SYNC_STAGES-1][PTR_W-1:PTR_W-2],
                         rd_gray_sync_q[SYNC_STAGES-1][PTR_W-3:0]};
      wr_ptr_d       = wr_rst_busy_d ? '0 : wr_ptr_q + PTR_W'(wr_push_c);
      wr_gray_d      = bin2gray(wr_ptr_d);
      full_d         = wr_rst_busy_d | (wr_gray_d == full_gray_c);
      wr_count_d     = wr_rst_busy_d ? '0 : wr_ptr_d - rd_ptr_sync_c;
      prog_full_d    = wr_rst_busy_d | (wr_count_d >= PF_TH);
      overflow_d     = wr_en & full_q & ~wr_rst_busy_q & ~srst;
   end

   always_ff @(posedge wr_clk) begin
      wr_rst_busy_q  <= wr_rst_busy_d;
      rd_ack_q       <= rd_ack_d;
      wr_ptr_q       <= wr_ptr_d;
      wr_gray_q      <= wr_gray_d;
      rd_gray_sync_q <= rd_gray_sync_d;
      full_q         <= full_d;
      prog_full_q    <= prog_full_d;
      overflow_q     <= overflow_d;
      wr_count_q     <= wr_count_d;
   end

   always_ff @(posedge wr_clk) begin
      if (wr_push_c) mem_q[wr_ptr_q[ADDR_W-1:0]] <= din;
   end

   // Read domain: the "next" reset level clears state so outputs are idle the cycle busy is seen.
   always_comb begin
      rd_rst_sync_d  = {rd_rst_sync_q[SYNC_STAGES-2:0], wr_rst_busy_q};
      rd_rst_now_c   = rd_rst_sync_q[SYNC_STAGES-1];
      rd_rst_next_c  = rd_rst_sync_d[SYNC_STAGES-1];
      wr_gray_sync_d = rd_rst_next_c ? '0 : {wr_gray_sync_q[SYNC_STAGES-2:0], wr_gray_q};
      wr_ptr_sync_c  = gray2bin(wr_gray_sync_q[SYNC_STAGES-1]);
      rd_data_c      = mem_q[rd_ptr_q[ADDR_W-1:0]];
`ifdef ASYNC_FIFO_FWFT_EN
      ram_pop_c      = ~ram_empty_q & ~rd_rst_now_c & (~valid_q | rd_en);
      valid_d        = ~rd_rst_next_c & (ram_pop_c | (valid_q & ~rd_en));
      underflow_d    = rd_en & ~valid_q & ~rd_rst_now_c & ~rd_rst_next_c;
`else
      ram_pop_c      = rd_en & ~ram_empty_q & ~rd_rst_now_c;
      valid_d        = ram_pop_c & ~rd_rst_next_c;
      underflow_d    = rd_en & ram_empty_q & ~rd_rst_now_c & ~rd_rst_next_c;
`endif
      rd_ptr_d       = rd_rst_next_c ? '0 : rd_ptr_q + PTR_W'(ram_pop_c);
      rd_gray_d      = bin2gray(rd_ptr_d);
      ram_empty_d    = rd_rst_next_c | (rd_gray_d == wr_gray_sync_q[SYNC_STAGES-1]);
      rd_count_d     = rd_rst_next_c ? '0 : wr_ptr_sync_c - rd_ptr_d;
      prog_empty_d   = rd_rst_next_c | (rd_count_d <= PE_TH);
      dout_d         = rd_rst_next_c ? '0 : (ram_pop_c ? rd_data_c : dout_q);
`ifdef ASYNC_FIFO_FWFT_EN
      empty_d        = ~valid_d;
`else
      empty_d        = ram_empty_d;
`endif
   end

   always_ff @(posedge rd_clk) begin
      rd_rst_sync_q  <= rd_rst_sync_d;
      wr_gray_sync_q <= wr_gray_sync_d;
      rd_ptr_q       <= rd_ptr_d;
      rd_gray_q      <= rd_gray_d;
      ram_empty_q    <= ram_empty_d;
      empty_q        <= empty_d;
      prog_empty_q   <= prog_empty_d;
      valid_q        <= valid_d;
      underflow_q    <= underflow_d;
      dout_q         <= dout_d;
      rd_count_q     <= rd_count_d;
   end

   assign full        = full_q;
   assign prog_full   = prog_full_q;
   assign wr_count    = wr_count_q;
   assign overflow    = overflow_q;
   assign wr_rst_busy = wr_rst_busy_q;
   assign dout        = dout_q;
   assign valid       = valid_q;
   assign empty       = empty_q;
   assign prog_empty  = prog_empty_q;
   assign rd_count    = rd_count_q;
   assign underflow   = underflow_q;
   assign rd_rst_busy = rd_rst_sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_async_fifo_gray.sv
// Directed bench for async_fifo_gray: reset handshake, fill/overflow, underflow, thresholds,
// mixed-rate traffic against a queue scoreboard, and mid-stream reset.
module tb_async_fifo_gray;

   localparam int unsigned DATA_W = 37;
   localparam int unsigned CNT_W  = 9;
`ifdef ASYNC_FIFO_FWFT_EN
   localparam int FW = 1;
`else
   localparam int FW = 0;
`endif

   logic              wr_clk = 1'b0;
   logic              rd_clk = 1'b0;
   logic              srst   = 1'b1;
   logic              wr_en  = 1'b0;
   logic              rd_en  = 1'b0;
   logic [DATA_W-1:0] din    = '0;
   logic              full, prog_full, overflow, wr_rst_busy;
   logic              valid, empty, prog_empty, underflow, rd_rst_busy;
   logic [CNT_W-1:0]  wr_count, rd_count;
   logic [DATA_W-1:0] dout;

   int n_checks = 0;
   int n_fail   = 0;
   int ovf_seen = 0;
   int unf_seen = 0;
   bit mon_en   = 1'b0;
   logic [DATA_W-1:0] sb [$];

   async_fifo_gray dut (
      .wr_clk(wr_clk), .srst(srst), .rd_clk(rd_clk),
      .din(din), .wr_en(wr_en), .full(full), .prog_full(prog_full),
      .wr_count(wr_count), .overflow(overflow), .wr_rst_busy(wr_rst_busy),
      .rd_en(rd_en), .dout(dout), .valid(valid), .empty(empty),
      .prog_empty(prog_empty), .rd_count(rd_count), .underflow(underflow),
      .rd_rst_busy(rd_rst_busy)
   );

   always #5  wr_clk = ~wr_clk;
   always #15 rd_clk = ~rd_clk;

   always @(posedge wr_clk) if (mon_en && overflow)  ovf_seen++;
   always @(posedge rd_clk) if (mon_en && underflow) unf_seen++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr_tick();
      @(posedge wr_clk); #1;
   endtask

   task automatic rd_tick();
      @(posedge rd_clk); #1;
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      int w = 0;
      while (full && w < 500) begin wr_tick(); w++; end
      if (full) check("push_wait_full", 64'(full), 64'd0);
      wr_en = 1'b1; din = d;
      wr_tick();
      wr_en = 1'b0;
   endtask

   task automatic pop(output logic [DATA_W-1:0] d);
      int w = 0;
`ifdef ASYNC_FIFO_FWFT_EN
      while (!valid && w < 200) begin rd_tick(); w++; end
      if (!valid) check("pop_wait_valid", 64'(valid), 64'd1);
      d = dout;
      rd_en = 1'b1;
      rd_tick();
      rd_en = 1'b0;
`else
      while (empty && w < 200) begin rd_tick(); w++; end
      if (empty) check("pop_wait_empty", 64'(empty), 64'd0);
      rd_en = 1'b1;
      rd_tick();
      rd_en = 1'b0;
      d = dout;
`endif
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DATA_W-1:0] d;
      int w;
      int errs;

      // reset held 3 wr cycles; outputs forced busy-safe
      srst = 1'b1;
      repeat (3) wr_tick();
      check("rst_wr_busy",  64'(wr_rst_busy), 64'd1);
      check("rst_full",     64'(full),        64'd1);
      check("rst_prog_full",64'(prog_full),   64'd1);
      check("rst_wr_count", 64'(wr_count),    64'd0);
      srst = 1'b0;
      w = 0;
      while (wr_rst_busy && w < 10) begin wr_tick(); w++; end
      check("wr_busy_release", 64'(wr_rst_busy), 64'd0);
      while (rd_rst_busy && w < 20) begin wr_tick(); w++; end
      check("rd_busy_release", 64'(rd_rst_busy), 64'd0);
      repeat (2) rd_tick();
      check("idle_empty",      64'(empty),      64'd1);
      check("idle_full",       64'(full),       64'd0);
      check("idle_wr_count",   64'(wr_count),   64'd0);
      check("idle_rd_count",   64'(rd_count),   64'd0);
      check("idle_prog_empty", 64'(prog_empty), 64'd1);
      check("idle_valid",      64'(valid),      64'd0);

      // read while empty: one underflow pulse, pointer untouched
      rd_en = 1'b1;
      rd_tick();
      rd_en = 1'b0;
      check("unf_pulse", 64'(underflow), 64'd1);
      check("unf_valid", 64'(valid),     64'd0);
      check("unf_empty", 64'(empty),     64'd1);
      rd_tick();
      check("unf_clear", 64'(underflow), 64'd0);
      check("unf_count", 64'(rd_count),  64'd0);
      wr_tick();
      push(37'h12_3456_789A);
      pop(d);
      check("unf_ptr_kept", 64'(d), 64'h12_3456_789A);
      repeat (6) rd_tick();

      // fill 0..255 with wr_en held, then one dropped write
      wr_tick();
      wr_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         din = DATA_W'(i);
         wr_tick();
      end
      check("fill_full",      64'(full),      64'd1);
      check("fill_wr_count",  64'(wr_count),  64'd256);
      check("fill_prog_full", 64'(prog_full), 64'd1);
      check("fill_no_ovf",    64'(overflow),  64'd0);
      din = DATA_W'(256);
      wr_tick();
      check("ovf_pulse", 64'(overflow), 64'd1);
      wr_en = 1'b0;
      wr_tick();
      check("ovf_clear", 64'(overflow), 64'd0);
      repeat (8) rd_tick();
      check("fill_rd_count",  64'(rd_count),   64'(256 - FW));
      check("fill_prog_empty",64'(prog_empty), 64'd0);
      for (int i = 0; i < 256; i++) begin
         pop(d);
         check("fill_order", 64'(d), 64'(i));
      end
      check("drain_empty",    64'(empty),    64'd1);
      check("drain_rd_count", 64'(rd_count), 64'd0);
      repeat (10) wr_tick();
      check("drain_full",     64'(full),     64'd0);
      check("drain_wr_count", 64'(wr_count), 64'd0);

      // programmable thresholds at 240 / 16
      for (int i = 0; i < 239; i++) push(DATA_W'(1000 + i));
      check("pf_239_count", 64'(wr_count),  64'd239);
      check("pf_239_flag",  64'(prog_full), 64'd0);
      push(DATA_W'(1239));
      check("pf_240_count", 64'(wr_count),  64'd240);
      check("pf_240_flag",  64'(prog_full), 64'd1);
      repeat (8) rd_tick();
      check("pe_240_count", 64'(rd_count),   64'(240 - FW));
      errs = 0;
      for (int k = 0; k < 223 - FW; k++) begin
         pop(d);
         if (d !== DATA_W'(1000 + k)) errs++;
      end
      check("pe_17_count", 64'(rd_count),   64'd17);
      check("pe_17_flag",  64'(prog_empty), 64'd0);
      pop(d);
      if (d !== DATA_W'(1223 - FW)) errs++;
      check("pe_16_count", 64'(rd_count),   64'd16);
      check("pe_16_flag",  64'(prog_empty), 64'd1);
      for (int k = 224 - FW; k < 240; k++) begin
         pop(d);
         if (d !== DATA_W'(1000 + k)) errs++;
      end
      check("thresh_data_errs", 64'(errs), 64'd0);
      check("thresh_empty",     64'(empty), 64'd1);

      // mixed-rate traffic with random gaps against a queue scoreboard
      errs = 0;
      mon_en = 1'b1;
      fork
         begin : writer
            logic [DATA_W-1:0] v;
            wr_tick();
            for (int i = 0; i < 600; i++) begin
               v = {5'($urandom), 32'($urandom)};
               sb.push_back(v);
               push(v);
               repeat ($urandom_range(0, 3)) wr_tick();
            end
         end
         begin : reader
            logic [DATA_W-1:0] r;
            logic [DATA_W-1:0] e;
            rd_tick();
            for (int i = 0; i < 600; i++) begin
               pop(r);
               if (sb.size() == 0) errs++;
               else begin
                  e = sb.pop_front();
                  if (r !== e) errs++;
               end
               repeat ($urandom_range(0, 2)) rd_tick();
            end
         end
      join
      mon_en = 1'b0;
      check("stress_data_errs", 64'(errs),     64'd0);
      check("stress_overflow",  64'(ovf_seen), 64'd0);
      check("stress_underflow", 64'(unf_seen), 64'd0);
      check("stress_sb_left",   64'(sb.size()),64'd0);

      // reset with 50 words held discards them all
      wr_tick();
      for (int i = 0; i < 50; i++) push(DATA_W'(5000 + i));
      repeat (8) rd_tick();
      check("mid_rd_count", 64'(rd_count), 64'(50 - FW));
      wr_tick();
      srst = 1'b1;
      repeat (3) wr_tick();
      srst = 1'b0;
      w = 0;
      while ((wr_rst_busy || rd_rst_busy) && w < 40) begin wr_tick(); w++; end
      check("mid_busy_release", 64'(wr_rst_busy | rd_rst_busy), 64'd0);
      repeat (6) rd_tick();
      check("mid_empty",    64'(empty),    64'd1);
      check("mid_rd_count0",64'(rd_count), 64'd0);
      check("mid_wr_count0",64'(wr_count), 64'd0);
      check("mid_valid",    64'(valid),    64'd0);
      wr_tick();
      push(37'h1A_5A5A_5A5A);
      pop(d);
      check("mid_first_word", 64'(d), 64'h1A_5A5A_5A5A);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
